rv_imm_decode_stage: RTL and testbench

- Registered immediate-generation stage for the RV32/RV64 decode path.
- Accepts a raw instruction with its format tag over a valid/ready handshake.
- Builds the sign- or zero-extended immediate for base formats (R/I/S/B/U/J) and, when enabled, every RVC compressed immediate kind.
- Presents the result one cycle later, supporting backpressure, pipeline flush and illegal-format flagging.

---
 rtl/rv_imm_decode_stage.sv | 82 ++++++++
 tb/tb_rv_imm_decode_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_imm_decode_stage.sv
// rv_imm_decode_stage: registered RV32/RV64 immediate generator with valid/ready, flush and illegal-format flag
module rv_imm_decode_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_C = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [5:0]      instruction_format,
  input  logic [3:0]      c_kind,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immediate,
  output logic            illegal
);
  logic [31:0]     i;
  logic [5:0]      f;
  logic            fmt_onehot;
  logic [63:0]     imm64;
  logic            bad;
  logic            accept;
  logic            out_valid_d, out_valid_q;
  logic            illegal_d, illegal_q;
  logic [XLEN-1:0] imm_d, imm_q;
  logic            unused_bits;
  assign i          = instruction;
  assign f          = instruction_format;
  assign fmt_onehot = (f != 6'd0) && ((f & (f - 6'd1)) == 6'd0);
  // built at 64 bits with sign already replicated, then truncated to XLEN
  always_comb begin
    imm64 = '0;
    bad   = 1'b0;
    if (c_kind == 4'd0) begin
      bad   = !fmt_onehot;
      imm64 = f[4] ? {{52{i[31]}}, i[31:20]} :
              f[3] ? {{52{i[31]}}, i[31:25], i[11:7]} :
              f[2] ? {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
              f[1] ? {{32{i[31]}}, i[31:12], 12'b0} :
              f[0] ? {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : 64'd0;
    end else begin
      bad = !ENABLE_C;
      case (c_kind)
        4'd1: imm64 = {{58{i[12]}}, i[12], i[6:2]};
        4'd2: imm64 = {{46{i[12]}}, i[12], i[6:2], 12'b0};
        4'd3: imm64 = {{54{i[12]}}, i[12], i[4:3], i[5], i[2], i[6], 4'b0};
        4'd4: imm64 = {56'd0, i[3:2], i[12], i[6:4], 2'b0};
        4'd5: imm64 = {56'd0, i[8:7], i[12:9], 2'b0};
        4'd6: imm64 = {54'd0, i[10:7], i[12:11], i[5], i[6], 2'b0};
        4'd7: imm64 = {57'd0, i[5], i[12:10], i[6], 2'b0};
        4'd8: imm64 = {{55{i[12]}}, i[12], i[6:5], i[2], i[11:10], i[4:3], 1'b0};
        4'd9: imm64 = {{52{i[12]}}, i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
        default: bad = 1'b1;
      endcase
    end
  end
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // flush wins over both a new accept and a held entry
  always_comb begin
    out_valid_d = flush ? 1'b0 : accept ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
    imm_d       = (accept && !flush) ? (bad ? '0 : imm64[XLEN-1:0]) : imm_q;
    illegal_d   = (accept && !flush) ? bad : illegal_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      imm_q       <= imm_d;
      illegal_q   <= illegal_d;
    end
  end
  assign out_valid   = out_valid_q;
  assign immediate   = imm_q;
  assign illegal     = illegal_q;
  assign unused_bits = ^{i[1:0], imm64};
endmodule

// File: tb/tb_rv_imm_decode_stage.sv
// tb_rv_imm_decode_stage: scoreboard bench driving a 32-bit/C-enabled and a 64-bit/C-disabled instance in lockstep
module tb_rv_imm_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic [5:0]  instruction_format = '0;
  logic [3:0]  c_kind = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, illegal;
  logic [31:0] immediate;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] immediate64;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] e32;
    bit          i32;
    logic [63:0] e64;
    bit          i64;
  } exp_t;
  exp_t sb[$];
  bit   ev = 1'b0;

  localparam logic [5:0] F_R = 6'b100000, F_I = 6'b010000, F_S = 6'b001000,
                         F_B = 6'b000100, F_U = 6'b000010, F_J = 6'b000001;

  rv_imm_decode_stage #(.XLEN(32), .ENABLE_C(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .instruction_format(instruction_format), .c_kind(c_kind),
    .out_valid(out_valid), .out_ready(out_ready), .immediate(immediate), .illegal(illegal));

  rv_imm_decode_stage #(.XLEN(64), .ENABLE_C(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instruction(instruction), .instruction_format(instruction_format), .c_kind(c_kind),
    .out_valid(out_valid64), .out_ready(out_ready), .immediate(immediate64), .illegal(illegal64));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint fld(input logic [31:0] ins, input int hi, input int lo);
    longint x;
    x = longint'({32'd0, ins});
    return (x >> lo) & ((64'sd1 << (hi - lo + 1)) - 1);
  endfunction

  // reference: assemble each immediate as a weighted sum of instruction fields
  function automatic void model(input logic [31:0] ins, input logic [5:0] fmt, input logic [3:0] ck,
                                input int xlen, input bit enc, output logic [63:0] imm, output bit ill);
    longint v = 0;
    int     w = 64;
    bit     s = 1'b0;
    ill = 1'b0;
    if (ck == 0) begin
      if ($countones(fmt) != 1) ill = 1'b1;
      else if (fmt == F_I) begin v = fld(ins, 31, 20); w = 12; s = 1; end
      else if (fmt == F_S) begin v = fld(ins, 31, 25) * 32 + fld(ins, 11, 7); w = 12; s = 1; end
      else if (fmt == F_B) begin
        v = fld(ins, 31, 31) * 4096 + fld(ins, 7, 7) * 2048 + fld(ins, 30, 25) * 32 + fld(ins, 11, 8) * 2;
        w = 13; s = 1;
      end
      else if (fmt == F_U) begin v = fld(ins, 31, 12) * 4096; w = 32; s = 1; end
      else if (fmt == F_J) begin
        v = fld(ins, 31, 31) * (1 << 20) + fld(ins, 19, 12) * 4096 + fld(ins, 20, 20) * 2048 + fld(ins, 30, 21) * 2;
        w = 21; s = 1;
      end
    end else if (ck > 9 || !enc) ill = 1'b1;
    else begin
      case (ck)
        1: begin v = fld(ins, 12, 12) * 32 + fld(ins, 6, 2); w = 6; s = 1; end
        2: begin v = (fld(ins, 12, 12) * 32 + fld(ins, 6, 2)) * 4096; w = 18; s = 1; end
        3: begin
          v = fld(ins, 12, 12) * 512 + fld(ins, 4, 3) * 128 + fld(ins, 5, 5) * 64 + fld(ins, 2, 2) * 32 + fld(ins, 6, 6) * 16;
          w = 10; s = 1;
        end
        4: v = fld(ins, 3, 2) * 64 + fld(ins, 12, 12) * 32 + fld(ins, 6, 4) * 4;
        5: v = fld(ins, 8, 7) * 64 + fld(ins, 12, 9) * 4;
        6: v = fld(ins, 10, 7) * 64 + fld(ins, 12, 11) * 16 + fld(ins, 5, 5) * 8 + fld(ins, 6, 6) * 4;
        7: v = fld(ins, 5, 5) * 64 + fld(ins, 12, 10) * 8 + fld(ins, 6, 6) * 4;
        8: begin
          v = fld(ins, 12, 12) * 256 + fld(ins, 6, 5) * 64 + fld(ins, 2, 2) * 32 + fld(ins, 11, 10) * 8 + fld(ins, 4, 3) * 2;
          w = 9; s = 1;
        end
        default: begin
          v = fld(ins, 12, 12) * 2048 + fld(ins, 8, 8) * 1024 + fld(ins, 10, 9) * 256 + fld(ins, 6, 6) * 128 +
              fld(ins, 7, 7) * 64 + fld(ins, 2, 2) * 32 + fld(ins, 11, 11) * 16 + fld(ins, 5, 3) * 2;
          w = 12; s = 1;
        end
      endcase
    end
    if (s && v[w-1]) v = v - (64'sd1 << w);
    if (ill) v = 0;
    imm = (xlen == 32) ? {32'd0, v[31:0]} : v;
  endfunction

  // issue side: every accepted, unflushed entry gets its expectation queued
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && in_valid && in_ready && !flush) begin
      model(instruction, instruction_format, c_kind, 32, 1'b1, e.e32, e.i32);
      model(instruction, instruction_format, c_kind, 64, 1'b0, e.e64, e.i64);
      sb.push_back(e);
    end
  end

  // monitor: compares presented outputs against the head of the queue
  always @(negedge clk) begin
    bit acc;
    if (!rst_n) begin
      ev = 1'b0;
      sb.delete();
    end else begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
      chk("out_valid64", {63'd0, out_valid64}, {63'd0, ev});
      chk("in_ready", {63'd0, in_ready}, {63'd0, !ev || out_ready});
      chk("in_ready64", {63'd0, in_ready64}, {63'd0, !ev || out_ready});
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: got out_valid=1 expected an entry queued at %0t", $time);
        end else begin
          chk("imm32", {32'd0, immediate}, sb[0].e32);
          chk("illegal32", {63'd0, illegal}, {63'd0, sb[0].i32});
          chk("imm64", immediate64, sb[0].e64);
          chk("illegal64", {63'd0, illegal64}, {63'd0, sb[0].i64});
          if (flush || out_ready) void'(sb.pop_front());
        end
      end
      acc = in_valid && (!ev || out_ready);
      ev  = flush ? 1'b0 : acc ? 1'b1 : (ev && out_ready) ? 1'b0 : ev;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [5:0] fmt, input logic [3:0] ck,
                       input bit ordy, input bit fl);
    in_valid = v;
    instruction = ins;
    instruction_format = fmt;
    c_kind = ck;
    out_ready = ordy;
    flush = fl;
  endtask

  initial begin
    repeat (3) cyc();
    rst_n = 1'b1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_imm", {32'd0, immediate}, 64'd0);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);
    chk("rst_imm64", immediate64, 64'd0);
    cyc();
    // I-type
    drive(1, 32'hFFF00093, F_I, 0, 1, 0);
    cyc();
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_imm32", {32'd0, immediate}, 64'h0000_0000_FFFF_FFFF);
    chk("t1_imm64", immediate64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_illegal", {63'd0, illegal}, 64'd0);
    // B, U, R back-to-back
    drive(1, 32'hFE000EE3, F_B, 0, 1, 0);
    cyc();
    chk("t2_valid_b", {63'd0, out_valid}, 64'd1);
    chk("t2_imm_b", {32'd0, immediate}, 64'h0000_0000_FFFF_FFFC);
    drive(1, 32'h123450B7, F_U, 0, 1, 0);
    cyc();
    chk("t2_valid_u", {63'd0, out_valid}, 64'd1);
    chk("t2_imm_u", {32'd0, immediate}, 64'h0000_0000_1234_5000);
    drive(1, 32'h002081B3, F_R, 0, 1, 0);
    cyc();
    chk("t2_valid_r", {63'd0, out_valid}, 64'd1);
    chk("t2_imm_r", {32'd0, immediate}, 64'd0);
    // compressed
    drive(1, 32'h000010FD, 6'd0, 1, 1, 0);
    cyc();
    chk("t3_addi", {32'd0, immediate}, 64'h0000_0000_FFFF_FFFF);
    chk("t3_noc_illegal", {63'd0, illegal64}, 64'd1);
    chk("t3_noc_imm", immediate64, 64'd0);
    drive(1, 32'h00004092, 6'd0, 4, 1, 0);
    cyc();
    chk("t3_lwsp", {32'd0, immediate}, 64'd4);
    drive(0, 0, 0, 0, 1, 0);
    cyc();
    // backpressure
    drive(1, 32'h00500093, F_I, 0, 0, 0);
    cyc();
    drive(1, 32'h00A00113, F_I, 0, 0, 0);
    repeat (3) begin
      cyc();
      chk("t4_in_ready", {63'd0, in_ready}, 64'd0);
      chk("t4_hold_imm", {32'd0, immediate}, 64'd5);
    end
    out_ready = 1'b1;
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_next_valid", {63'd0, out_valid}, 64'd1);
    chk("t4_next_imm", {32'd0, immediate}, 64'd10);
    out_ready = 1'b1;
    cyc();
    // flush while holding
    drive(1, 32'h00500093, F_I, 0, 0, 0);
    cyc();
    drive(1, 32'h00A00113, F_I, 0, 0, 1);
    cyc();
    chk("t5_flushed", {63'd0, out_valid}, 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk("t5_dropped", {63'd0, out_valid}, 64'd0);
    // illegal format then async reset mid-hold
    drive(1, 32'h12345678, 6'b000110, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("t6_illegal", {63'd0, illegal}, 64'd1);
    chk("t6_imm", {32'd0, immediate}, 64'd0);
    chk("t6_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_rst", {63'd0, out_valid}, 64'd0);
    chk("t6_async_rst64", {63'd0, out_valid64}, 64'd0);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom,
            ($urandom_range(0, 4) != 0) ? 6'(1 << $urandom_range(0, 5)) : 6'($urandom_range(0, 63)),
            ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 15)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      cyc();
    end
    drive(0, 0, 0, 0, 1, 0);
    repeat (3) cyc();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
